// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader, the memory and the bench.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 1024;
  localparam int unsigned IMEM_AW    = 10;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    FINISH,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word.
// o_word already includes the byte being pushed this cycle, so the caller can
// register the complete word on the same edge that accepts the 4th byte.
module byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full_pulse
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic [31:0] w_word;

  // Merge the incoming byte into the partial word at the current byte lane.
  always_comb begin
    w_word = r_word;
    if (i_push) begin
      w_word[8*r_idx +: 8] = i_byte;
    end
  end

  assign o_word       = w_word;
  assign o_full_pulse = i_push && (r_idx == 2'd3);

  // Byte lane counter and partial word; cleared on reset, explicit clear and word completion.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_push) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= (r_idx == 2'd3) ? '0 : w_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed little-endian word stream and
// writes it into instruction memory, holding the core until the image is complete.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH   = IMEM_DEPTH,
  parameter int unsigned AW      = IMEM_AW,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_rx_valid,
  input  logic [7:0]    i_rx_data,
  output logic          o_rx_ready,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [31:0]   o_wdata,
  output logic          o_core_hold,
  output logic          o_done,
  output logic          o_error
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  loader_state_t r_state, w_state_next;
  logic          r_rx_ready, w_rx_ready_next;
  logic          r_we, w_we_next;
  logic [AW-1:0] r_waddr, w_waddr_next;
  logic [31:0]   r_wdata, w_wdata_next;
  logic          r_core_hold, w_core_hold_next;
  logic          r_done, w_done_next;
  logic          r_error, w_error_next;
  logic [15:0]   r_len, w_len_next;
  logic [AW-1:0] r_word_idx, w_word_idx_next;
  logic [TW-1:0] r_timer, w_timer_next;

  logic          w_accept;
  logic          w_push;
  logic          w_clr;
  logic [31:0]   w_word;
  logic          w_full;
  logic [15:0]   w_len_full;
  logic          w_last_word;

  assign w_accept    = i_rx_valid && r_rx_ready;
  assign w_push      = w_accept && (r_state == DATA);
  assign w_len_full  = {i_rx_data, r_len[7:0]};
  assign w_last_word = (16'(r_word_idx) == (r_len - 16'd1));

  byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_push      (w_push),
    .i_byte      (i_rx_data),
    .o_word      (w_word),
    .o_full_pulse(w_full)
  );

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    w_state_next     = r_state;
    w_we_next        = 1'b0;
    w_waddr_next     = r_waddr;
    w_wdata_next     = r_wdata;
    w_core_hold_next = r_core_hold;
    w_done_next      = r_done;
    w_error_next     = r_error;
    w_len_next       = r_len;
    w_word_idx_next  = r_word_idx;
    w_timer_next     = r_timer;
    w_clr            = 1'b0;

    unique case (r_state)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          w_state_next     = LEN_LO;
          w_done_next      = 1'b0;
          w_error_next     = 1'b0;
          w_core_hold_next = 1'b1;
          w_timer_next     = '0;
          w_clr            = 1'b1;
        end
      end
      LEN_LO, LEN_HI, DATA: begin
        if (w_accept) begin
          w_timer_next = '0;
          if (r_state == LEN_LO) begin
            w_len_next   = {r_len[15:8], i_rx_data};
            w_state_next = LEN_HI;
          end else if (r_state == LEN_HI) begin
            w_len_next = w_len_full;
            if ((w_len_full == 16'd0) || (w_len_full > 16'(DEPTH))) begin
              w_state_next = ERR;
              w_error_next = 1'b1;
            end else begin
              w_state_next    = DATA;
              w_word_idx_next = '0;
              w_clr           = 1'b1;
            end
          end else if (w_full) begin
            w_we_next       = 1'b1;
            w_waddr_next    = r_word_idx;
            w_wdata_next    = w_word;
            w_word_idx_next = r_word_idx + 1'b1;
            if (w_last_word) begin
              w_state_next = FINISH;
            end
          end
        end else begin
          w_timer_next = r_timer + 1'b1;
          if (w_timer_next == TW'(TIMEOUT)) begin
            // Idle too long: abort and drop any partial word.
            w_state_next = ERR;
            w_error_next = 1'b1;
            w_clr        = 1'b1;
          end
        end
      end
      FINISH: begin
        w_state_next     = DONE;
        w_done_next      = 1'b1;
        w_core_hold_next = 1'b0;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_rx_ready_next = (w_state_next == LEN_LO) || (w_state_next == LEN_HI) ||
                      (w_state_next == DATA);
  end

  // State and output registers; synchronous reset also kills a pending write strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rx_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_core_hold <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rx_ready  <= w_rx_ready_next;
      r_we        <= w_we_next;
      r_waddr     <= w_waddr_next;
      r_wdata     <= w_wdata_next;
      r_core_hold <= w_core_hold_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
      r_len       <= w_len_next;
      r_word_idx  <= w_word_idx_next;
      r_timer     <= w_timer_next;
    end
  end

  assign o_rx_ready  = r_rx_ready;
  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_core_hold = r_core_hold;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule
